// File: rtl/rotating_shift_engine.sv
// rotating_shift_engine
// Parametrised shift/rotate register with parallel load, single-step shifting
// and a counted multi-step run that reports completion with a one-cycle pulse.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-high reset, clears all state
//   load   - synchronous parallel load of d (aborts a run, no done pulse)
//   d      - parallel load data
//   en     - single shift per cycle while idle, using the live controls
//   mode   - 00 rotate, 01 logical, 10 arithmetic, 11 hold
//   dir    - 0 shifts toward the MSB, 1 toward the LSB
//   sin    - serial fill bit for logical shifts (and left arithmetic shifts)
//   start  - begin a counted run of `steps` shifts
//   steps  - run length, 0 goes straight to completion
//   q      - register contents
//   sout   - last bit shifted out of q
//   busy   - high while a counted run is in progress
//   done   - one-cycle completion pulse of a counted run
module rotating_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             sout_r, sout_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [1:0]       run_mode_r, run_mode_s;
  logic             run_dir_r, run_dir_s;
  logic             run_sin_r, run_sin_s;

  // One shift step; returns {new sout, new q}. Hold keeps both untouched.
  function automatic logic [WIDTH:0] shift_f(
    input logic [WIDTH-1:0] cur_q,
    input logic             cur_sout,
    input logic [1:0]       f_mode,
    input logic             f_dir,
    input logic             f_sin
  );
    logic [WIDTH:0] res;
    res = {cur_sout, cur_q};
    case (f_mode)
      2'b00: begin
        if (f_dir == 1'b0) begin
          res = {cur_q[WIDTH-1], cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
        end else begin
          res = {cur_q[0], cur_q[0], cur_q[WIDTH-1:1]};
        end
      end
      2'b01: begin
        if (f_dir == 1'b0) begin
          res = {cur_q[WIDTH-1], cur_q[WIDTH-2:0], f_sin};
        end else begin
          res = {cur_q[0], f_sin, cur_q[WIDTH-1:1]};
        end
      end
      2'b10: begin
        // A left arithmetic shift is identical to a left logical shift.
        if (f_dir == 1'b0) begin
          res = {cur_q[WIDTH-1], cur_q[WIDTH-2:0], f_sin};
        end else begin
          res = {cur_q[0], cur_q[WIDTH-1], cur_q[WIDTH-1:1]};
        end
      end
      default: res = {cur_sout, cur_q};
    endcase
    return res;
  endfunction

  // Next-state logic: load overrides everything, then the state machine.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    q_s        = q_r;
    sout_s     = sout_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    run_mode_s = run_mode_r;
    run_dir_s  = run_dir_r;
    run_sin_s  = run_sin_r;
    if (load) begin
      q_s     = d;
      state_s = IDLE;
      cnt_s   = {CNT_W{1'b0}};
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            run_mode_s = mode;
            run_dir_s  = dir;
            run_sin_s  = sin;
            cnt_s      = steps;
            if (steps == {CNT_W{1'b0}}) begin
              state_s = DONE;
              done_s  = 1'b1;
            end else begin
              state_s = RUN;
              busy_s  = 1'b1;
            end
          end else if (en) begin
            {sout_s, q_s} = shift_f(q_r, sout_r, mode, dir, sin);
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          {sout_s, q_s} = shift_f(q_r, sout_r, run_mode_r, run_dir_r, run_sin_r);
          cnt_s = cnt_r - CNT_W'(1);
          // The edge that empties the counter does the final shift.
          if (cnt_r == CNT_W'(1)) begin
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      q_r        <= {WIDTH{1'b0}};
      sout_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      run_mode_r <= 2'b00;
      run_dir_r  <= 1'b0;
      run_sin_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      q_r        <= q_s;
      sout_r     <= sout_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      run_mode_r <= run_mode_s;
      run_dir_r  <= run_dir_s;
      run_sin_r  <= run_sin_s;
    end
  end

  assign q    = q_r;
  assign sout = sout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: doc/rotating_shift_engine.md
# rotating_shift_engine

Parametrised shift/rotate register with synchronous load, single-step operation and a counted multi-step command. Modes are rotate, logical shift and arithmetic shift, in either direction, with serial in and out. It replaces the fixed 4-bit left-rotate register in datapaths that need wider words, both directions, or a bounded N-step shift with completion signalling. All control is synchronous except reset.

## Interface
- WIDTH, 8, data width in bits; must be ≥ 2.
- CNT_W, 4, width of the steps input; the maximum run length is 2^CNT_W − 1.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- load  input  1  synchronous parallel load of d into q.
- d  input  WIDTH  parallel load data.
- en  input  1  single-step enable: one shift per cycle while in IDLE.
- mode  input  2  shift type:
  - 00: rotate.
  - 01: logical shift.
  - 10: arithmetic shift.
  - 11: hold.
- dir  input  1  shift direction: 0 = left (toward MSB), 1 = right.
- sin  input  1  serial fill bit for logical shifts.
- start  input  1  begin a counted run of steps shifts.
- steps  input  CNT_W  run length.
- q  output  WIDTH  register contents.
- sout  output  1  the last bit shifted out of q.
- busy  output  1  high while a counted run is in progress.
- done  output  1  one-cycle pulse when a counted run completes.

## Operation
- States:
  - IDLE: accepts load, start and en.
  - RUN: performs one shift per cycle and decrements the step counter.
  - DONE: a single cycle that asserts done, then returns to IDLE.
- Priority on each edge is reset > load > start > en.
  - load in any state: q ← d, sout unchanged, next state IDLE. An in-progress run is aborted and done is not pulsed.
  - start in IDLE with steps = N ≥ 1:
    - latch mode, dir and sin into run registers;
    - set the step counter to N and enter RUN;
    - q is not shifted on the start edge.
  - start in IDLE with steps = 0: go directly to DONE; q is unchanged.
  - start or en while in RUN or DONE: ignored.
  - en in IDLE (start low): one shift using the live mode, dir and sin.
- Single-shift function, with the outgoing bit copied to sout:
  - Rotate left: q ← {q[W-2:0], q[W-1]}; sout ← q[W-1].
  - Rotate right: q ← {q[0], q[W-1:1]}; sout ← q[0].
  - Logical left or arithmetic left: q ← {q[W-2:0], sin}; sout ← q[W-1].
  - Logical right: q ← {sin, q[W-1:1]}; sout ← q[0].
  - Arithmetic right: q ← {q[W-1], q[W-1:1]}; sout ← q[0].
  - Hold (mode 11): q and sout unchanged. During a run the counter still decrements.
- RUN behaviour: each edge performs one shift with the latched controls and decrements the counter. The edge that brings the counter to 0 performs the final shift and moves the state to DONE.
- Step counts above WIDTH are legal: rotates wrap modulo WIDTH, and shifts saturate to an all-fill pattern.

## Timing
- Reset values: q = 0, sout = 0, busy = 0, done = 0, state IDLE, counter 0.
- Reset takes effect asynchronously, including in the middle of a run.
- Single step: q updates on the edge where en is sampled, giving a latency of 1 cycle.
- Counted run with start sampled at edge k and steps = N:
  - shifts occur at edges k+1 through k+N;
  - busy is high from after edge k until after edge k+N, i.e. for N cycles;
  - done is high for exactly the one cycle following edge k+N;
  - total latency is N+1 edges to done.
- steps = 0: busy never rises; done is high in the cycle after edge k.
- A new start is accepted in the cycle after done, when the state is back in IDLE.
- Changes to mode, dir or sin during RUN have no effect on the run in progress.

## Test plan
- Reset during a 5-step run, after edge 2: q, sout, busy and done go to 0 without waiting for an edge. After reset is released, en with mode 00 and q = 0 leaves q = 8'h00.
- Load 8'hA5, then en=1, mode=00, dir=0 for one cycle: q = 8'h4B, sout = 1.
- Load 8'h81, then start with steps=3, mode=00, dir=1:
  - q sequence is C0, 60, 30;
  - busy is high for 3 cycles;
  - done pulses once;
  - final sout = 0.
- Load 8'h90, then start with steps=2, mode=10, dir=1: q sequence is C8, E4; sout = 0; done pulses once.
- Load 8'h00, then start with steps=8, mode=01, dir=0, sin=1, with sin toggled mid-run: q reaches 8'hFF after the eighth edge, confirming sin was latched.
- start with steps=0: done is high in the next cycle, busy stays 0, q is unchanged.
- Load during a run: start with steps=5, then assert load with d=8'h3C at the second RUN edge.
  - Expected: q = 8'h3C, busy drops, no done pulse.
  - en pulsed during RUN causes no extra shift.
